// File: rtl/inv_sbox_decoder.sv
// Inverse S-box decoder: loads a 256-entry S-box, builds and checks its inverse, then decrypts a pixel stream.
// Optional chained decryption is enabled by defining INV_SBOX_CHAIN_EN.
module inv_sbox_decoder #(
  parameter logic [7:0] IV     = 8'h5A,
  parameter int         RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       sbox_re,
  output logic [7:0] sbox_addr,
  input  logic [7:0] sbox_data,
  input  logic       ct_valid,
  output logic       ct_ready,
  input  logic [7:0] ct_data,
  output logic       pt_valid,
  input  logic       pt_ready,
  output logic [7:0] pt_data,
  output logic       table_ok,
  output logic       err_dup
);

  generate
    if (RD_LAT != 1) begin : g_rd_lat_check
      $error("inv_sbox_decoder: only RD_LAT=1 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERR} state_t;

  state_t       state;
  logic [8:0]   cnt;
  logic         rd_d1;
  logic [7:0]   addr_d1;
  logic [255:0] hit;
  logic [7:0]   inv_mem [256];

  logic capture;
  logic dup;
  logic accept;
  logic [7:0] inv_val;

  // A return is captured only while the table is still being built.
  assign capture  = rd_d1 && ((state == LOAD) || (state == FLUSH));
  assign dup      = capture && hit[sbox_data];
  assign ct_ready = (state == RUN) && (!pt_valid || pt_ready);
  assign accept   = ct_valid && ct_ready;
  assign inv_val  = inv_mem[ct_data];

`ifdef INV_SBOX_CHAIN_EN
  logic [7:0] prev;
`else
  logic unused_iv;
  assign unused_iv = ^IV;
`endif

  always_ff @(posedge clk) begin
    if (capture) begin
      inv_mem[sbox_data] <= addr_d1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sbox_re   <= 1'b0;
      sbox_addr <= '0;
      rd_d1     <= 1'b0;
      addr_d1   <= '0;
      hit       <= '0;
      pt_valid  <= 1'b0;
      pt_data   <= '0;
      table_ok  <= 1'b0;
      err_dup   <= 1'b0;
`ifdef INV_SBOX_CHAIN_EN
      prev      <= IV;
`endif
    end else begin
      rd_d1   <= sbox_re;
      addr_d1 <= sbox_addr;
      if (capture) begin
        hit[sbox_data] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            hit      <= '0;
            cnt      <= '0;
            table_ok <= 1'b0;
          end
        end
        LOAD: begin
          if (dup) begin
            state   <= ERR;
            err_dup <= 1'b1;
            sbox_re <= 1'b0;
          end else if (cnt[8]) begin
            // All 256 addresses issued; FLUSH absorbs the final return.
            sbox_re <= 1'b0;
            state   <= FLUSH;
          end else begin
            sbox_re   <= 1'b1;
            sbox_addr <= cnt[7:0];
            cnt       <= cnt + 9'd1;
          end
        end
        FLUSH: begin
          if (dup) begin
            state   <= ERR;
            err_dup <= 1'b1;
          end else begin
            table_ok <= 1'b1;
            state    <= RUN;
`ifdef INV_SBOX_CHAIN_EN
            prev     <= IV;
`endif
          end
        end
        RUN: begin
          if (accept) begin
`ifdef INV_SBOX_CHAIN_EN
            pt_data <= inv_val ^ prev;
            prev    <= ct_data;
`else
            pt_data <= inv_val;
`endif
            pt_valid <= 1'b1;
          end else if (pt_ready) begin
            pt_valid <= 1'b0;
          end
        end
        ERR: begin
          sbox_re  <= 1'b0;
          pt_valid <= 1'b0;
          table_ok <= 1'b0;
          err_dup  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbox_decoder.sv
// Directed self-checking bench for inv_sbox_decoder; S-box memory modelled with a 1-cycle registered read.
module tb_inv_sbox_decoder;
  localparam logic [7:0] IV = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sbox_re;
  logic [7:0] sbox_addr;
  logic [7:0] sbox_data;
  logic       ct_valid;
  logic       ct_ready;
  logic [7:0] ct_data;
  logic       pt_valid;
  logic       pt_ready;
  logic [7:0] pt_data;
  logic       table_ok;
  logic       err_dup;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem   [256];
  logic [7:0] inv_m [256];
  logic [7:0] prev_m;
  logic [7:0] q [$];

  inv_sbox_decoder #(.IV(IV), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sbox_re(sbox_re), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .table_ok(table_ok), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sbox_re) sbox_data <= mem[sbox_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_re"}, sbox_re, 0);
    chk({tag, "_addr"}, sbox_addr, 0);
    chk({tag, "_ctrdy"}, ct_ready, 0);
    chk({tag, "_ptv"}, pt_valid, 0);
    chk({tag, "_ptd"}, pt_data, 0);
    chk({tag, "_ok"}, table_ok, 0);
    chk({tag, "_err"}, err_dup, 0);
  endtask

  function automatic logic [7:0] model(input logic [7:0] c);
    logic [7:0] r;
    r = inv_m[c];
`ifdef INV_SBOX_CHAIN_EN
    r = r ^ prev_m;
    prev_m = c;
`endif
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Full load: reads 0..255 on consecutive cycles, table_ok exactly 258 cycles after start.
  task automatic load_check(input string tag);
    do_start();
    chk({tag, "_re0"}, sbox_re, 0);
    for (int n = 1; n <= 258; n++) begin
      tick();
      if (n <= 256) begin
        chk({tag, "_re"}, sbox_re, 1);
        chk({tag, "_addr"}, sbox_addr, n - 1);
      end else begin
        chk({tag, "_reoff"}, sbox_re, 0);
      end
      chk({tag, "_ok"}, table_ok, (n == 258) ? 1 : 0);
    end
    for (int i = 0; i < 256; i++) inv_m[mem[i]] = 8'(i);
    prev_m = IV;
    $display("load %s table_ok=%0d", tag, table_ok);
  endtask

  task automatic send1(input string tag, input logic [7:0] c, input logic [7:0] e);
    ct_valid = 1'b1;
    ct_data  = c;
    pt_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, ct_ready, 1);
    tick();
    ct_valid = 1'b0;
    chk({tag, "_v"}, pt_valid, 1);
    chk(tag, pt_data, e);
    $display("px %s ct=%02h pt=%02h exp=%02h", tag, c, pt_data, e);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int got;
    logic [31:0] head;

    rst = 1'b0; start = 1'b0; ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b0;
    tick(); tick();
    chk_zero("rst");
    rst = 1'b1;
    tick();
    chk_zero("idle");

    // Identity S-box
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    load_check("ident");
`ifdef INV_SBOX_CHAIN_EN
    send1("chain0", 8'h10, 8'h4A);
    send1("chain1", 8'h20, 8'h30);
    send1("id00", 8'h00, 8'h20);
    send1("id7f", 8'h7F, 8'h7F);
    send1("idff", 8'hFF, 8'h80);
`else
    send1("chain0", 8'h10, 8'h10);
    send1("chain1", 8'h20, 8'h20);
    send1("id00", 8'h00, 8'h00);
    send1("id7f", 8'h7F, 8'h7F);
    send1("idff", 8'hFF, 8'hFF);
`endif
    tick();
    chk("drain_v", pt_valid, 0);
    do_start();
    chk("run_ign_start", table_ok, 1);

    // Reset mid-RUN discards the held pixel
    ct_valid = 1'b1; ct_data = 8'h55; pt_ready = 1'b0;
    tick();
    ct_valid = 1'b0;
    chk("hold_v", pt_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_run");
    tick();
    rst = 1'b1;
    tick();

    // Shifted S-box, continuous 256-pixel stream
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    load_check("shift");
    pt_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ct_valid = 1'b1;
      ct_data  = 8'(i);
      #1;
      chk("str_rdy", ct_ready, 1);
      tick();
      chk("str_v", pt_valid, 1);
      chk("str_d", pt_data, model(8'(i)));
      if (i < 2 || i == 255) $display("px stream ct=%02h pt=%02h", i, pt_data);
    end
    ct_valid = 1'b0;
    tick();
    chk("str_end", pt_valid, 0);

    // Backpressure: pt_ready low for 5 cycles mid-stream
    q.delete(); sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 20; c++) begin
      pt_ready = !(c >= 5 && c < 10);
      ct_valid = (sent < 20);
      ct_data  = 8'(8'h30 + sent);
      #1;
      chk("bp_rdy", ct_ready, (!pt_valid || pt_ready) ? 1 : 0);
      if (c >= 5 && c < 10) chk("bp_hold_v", pt_valid, 1);
      if (pt_valid) begin
        head = (q.size() > 0) ? {24'd0, q[0]} : 32'h100;
        if (pt_ready) begin
          chk("bp_data", pt_data, head);
          if (q.size() > 0) void'(q.pop_front());
          got++;
        end else begin
          chk("bp_hold_d", pt_data, head);
        end
      end
      if (ct_valid && ct_ready) begin
        q.push_back(model(ct_data));
        sent++;
      end
      tick();
    end
    ct_valid = 1'b0;
    pt_ready = 1'b1;
    chk("bp_count", got, 20);
    $display("backpressure sent=%0d got=%0d", sent, got);

    // Reset during LOAD at addr 100, then full reload
    reset_pulse();
    do_start();
    for (int n = 1; n <= 101; n++) tick();
    chk("mid_addr", sbox_addr, 100);
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_load");
    tick();
    rst = 1'b1;
    tick();
    load_check("reload");
    send1("rl0", 8'h00, model(8'h00));
    send1("rl1", 8'h80, model(8'h80));

    // Duplicate: 0x11 at addr 3 and 200
    reset_pulse();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[3] = 8'h11; mem[8'h11] = 8'h03; mem[200] = 8'h11;
    do_start();
    for (int n = 1; n <= 270; n++) begin
      tick();
      chk("dup_err", err_dup, (n >= 203) ? 1 : 0);
      chk("dup_ok", table_ok, 0);
    end
    ct_valid = 1'b1; pt_ready = 1'b1;
    do_start();
    tick();
    chk("dup_ctrdy", ct_ready, 0);
    chk("dup_ptv", pt_valid, 0);
    chk("dup_sticky", err_dup, 1);
    ct_valid = 1'b0;
    $display("dup err_dup=%0d table_ok=%0d", err_dup, table_ok);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
